// File: rtl/popcount_sched_pkg.sv
// rtl/popcount_sched_pkg.sv - shared types and default sizing for the popcount job scheduler
package popcount_sched_pkg;

  localparam int DATA_W       = 8;
  localparam int NUM_REQ      = 2;
  localparam int TARGET_COUNT = 4;

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int ID_W  = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, searches upward from ptr with wrap-around
module rr_arbiter #(
  parameter int NUM_REQ = popcount_sched_pkg::NUM_REQ,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx
);

  logic found;
  int   j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (en && !found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/popcount_job_scheduler.sv
// rtl/popcount_job_scheduler.sv - round-robin front end for the shift/count/compare popcount datapath
// Optional early termination once the count passes the target: POPCOUNT_EARLY_EXIT_EN
module popcount_job_scheduler #(
  parameter int DATA_W       = popcount_sched_pkg::DATA_W,
  parameter int NUM_REQ      = popcount_sched_pkg::NUM_REQ,
  parameter int TARGET_COUNT = popcount_sched_pkg::TARGET_COUNT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]     req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
  output logic [$clog2(DATA_W+1)-1:0]   rsp_count,
  output logic                          rsp_match,
  output logic                          led,
  output logic                          busy
);
  import popcount_sched_pkg::*;

  localparam int CNT_BITS = $clog2(DATA_W + 1);
  localparam int ID_BITS  = $clog2(NUM_REQ);

  state_t              state_q;
  logic [ID_BITS-1:0]  ptr_q;
  logic [ID_BITS-1:0]  id_q;
  logic [DATA_W-1:0]   op_q;
  logic [CNT_BITS-1:0] cnt_q;
  logic                led_q;
  logic [NUM_REQ-1:0]  gnt;
  logic [ID_BITS-1:0]  gnt_idx;
  logic [CNT_BITS-1:0] cnt_next;

  // Grants are suppressed during reset so no requester sees a phantom accept.
  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_BITS)) u_arb (
    .req (req_valid),
    .ptr (ptr_q),
    .en  ((state_q == IDLE) && !rst),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  assign cnt_next  = cnt_q + CNT_BITS'(op_q[0]);
  assign req_ready = gnt;
  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = id_q;
  assign rsp_count = cnt_q;
  assign rsp_match = (state_q == RESP) && (cnt_q == CNT_BITS'(TARGET_COUNT));
  assign led       = led_q;
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      led_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|gnt) begin
            op_q    <= req_data[int'(gnt_idx)*DATA_W +: DATA_W];
            cnt_q   <= '0;
            id_q    <= gnt_idx;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (op_q == '0) begin
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_next;
            op_q  <= op_q >> 1;
`ifdef POPCOUNT_EARLY_EXIT_EN
            if ((TARGET_COUNT < DATA_W) && (cnt_next == CNT_BITS'(TARGET_COUNT + 1)))
              state_q <= RESP;
`endif
          end
        end
        RESP: begin
          if (rsp_ready) begin
            led_q   <= rsp_match;
            ptr_q   <= (id_q == ID_BITS'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_popcount_job_scheduler.sv
// tb/tb_popcount_job_scheduler.sv - directed self-checking bench for popcount_job_scheduler
module tb_popcount_job_scheduler;

  localparam int CW = popcount_sched_pkg::CNT_W;
  localparam int IW = popcount_sched_pkg::ID_W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    req_valid = 2'b00;
  logic [15:0]   req_data = 16'h0;
  logic [1:0]    req_ready;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [IW-1:0] rsp_id;
  logic [CW-1:0] rsp_count;
  logic          rsp_match;
  logic          led;
  logic          busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  popcount_job_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_count (rsp_count),
    .rsp_match (rsp_match),
    .led       (led),
    .busy      (busy)
  );

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_grant(output int t, output logic [1:0] g, output bit ok);
    ok = 1'b0; g = 2'b00; t = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (req_ready !== 2'b00) begin
        ok = 1'b1; g = req_ready; t = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_rsp(output int t, output bit ok);
    ok = 1'b0; t = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (rsp_valid === 1'b1) begin
        ok = 1'b1; t = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({rsp_valid, busy, led, req_ready, rsp_id, rsp_count, rsp_match} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got valid=%b busy=%b led=%b ready=%b id=%0d cnt=%0d match=%b want all 0",
               rsp_valid, busy, led, req_ready, rsp_id, rsp_count, rsp_match);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({rsp_valid, busy, req_ready} !== '0) begin
      bad++;
      $display("FAIL post_reset_idle: got valid=%b busy=%b ready=%b want 0", rsp_valid, busy, req_ready);
    end
  endtask

  task automatic test_single();
    int ta, tr;
    logic [1:0] g;
    bit ok;
    do_reset();
    rsp_ready = 1'b1;
    req_data = 16'h000F;
    req_valid = 2'b01;
    wait_grant(ta, g, ok);
    total++;
    if (!ok || g !== 2'b01) begin
      bad++; $display("FAIL single_grant: got %b ok=%0d want 01", g, ok);
    end
    @(posedge clk); #1 req_valid = 2'b00;
    wait_rsp(tr, ok);
    total++;
    if (!ok || (tr - ta) !== 6) begin
      bad++; $display("FAIL single_latency: got %0d ok=%0d want 6", tr - ta, ok);
    end
    total++;
    if (rsp_id !== 1'b0 || rsp_count !== 4'd4 || rsp_match !== 1'b1) begin
      bad++; $display("FAIL single_result: got id=%0d cnt=%0d match=%b want 0/4/1", rsp_id, rsp_count, rsp_match);
    end
    @(negedge clk);
    total++;
    if (led !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL single_led: got led=%b busy=%b want 1/0", led, busy);
    end
  endtask

  task automatic test_priority();
    int ta, tr;
    logic [1:0] g;
    bit ok;
    rst = 1'b1;
    req_data = 16'h00FF;
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_grant(ta, g, ok);
    total++;
    if (!ok || g !== 2'b01) begin
      bad++; $display("FAIL prio_first_grant: got %b want 01", g);
    end
    @(posedge clk); #1 req_valid = 2'b10;
    wait_rsp(tr, ok);
    total++;
    if (!ok || (tr - ta) !== 10 || rsp_id !== 1'b0 || rsp_count !== 4'd8 || rsp_match !== 1'b0) begin
      bad++; $display("FAIL prio_ff_result: got lat=%0d id=%0d cnt=%0d match=%b want 10/0/8/0", tr - ta, rsp_id, rsp_count, rsp_match);
    end
    @(negedge clk);
    wait_grant(ta, g, ok);
    total++;
    if (!ok || g !== 2'b10) begin
      bad++; $display("FAIL prio_second_grant: got %b want 10", g);
    end
    @(posedge clk); #1 req_valid = 2'b00;
    wait_rsp(tr, ok);
    total++;
    if (!ok || (tr - ta) !== 2 || rsp_id !== 1'b1 || rsp_count !== 4'd0 || rsp_match !== 1'b0) begin
      bad++; $display("FAIL prio_zero_result: got lat=%0d id=%0d cnt=%0d match=%b want 2/1/0/0", tr - ta, rsp_id, rsp_count, rsp_match);
    end
    @(negedge clk);
    total++;
    if (led !== 1'b0) begin
      bad++; $display("FAIL prio_led: got %b want 0", led);
    end
  endtask

  task automatic test_back_to_back();
    int ta, tr;
    logic [1:0] g;
    bit ok;
    logic [1:0] exp_g;
    do_reset();
    rsp_ready = 1'b1;
    req_data = 16'h0301;
    req_valid = 2'b11;
    for (int n = 0; n < 6; n++) begin
      exp_g = (n % 2 == 0) ? 2'b01 : 2'b10;
      wait_grant(ta, g, ok);
      total++;
      if (!ok || g !== exp_g) begin
        bad++; $display("FAIL alt_grant_%0d: got %b want %b", n, g, exp_g);
      end
      wait_rsp(tr, ok);
      total++;
      if (!ok || rsp_id !== exp_g[1] || rsp_count !== ((n % 2 == 0) ? 4'd1 : 4'd2)) begin
        bad++; $display("FAIL alt_rsp_%0d: got id=%0d cnt=%0d want id=%0d", n, rsp_id, rsp_count, exp_g[1]);
      end
      if (n == 5) req_valid = 2'b00;
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    int ta, tr;
    logic [1:0] g;
    bit ok;
    int errs;
    do_reset();
    rsp_ready = 1'b0;
    req_data = 16'h0503;
    req_valid = 2'b11;
    wait_grant(ta, g, ok);
    total++;
    if (!ok || g !== 2'b01) begin
      bad++; $display("FAIL bp_grant0: got %b want 01", g);
    end
    @(posedge clk); #1 req_valid = 2'b10;
    wait_rsp(tr, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL bp_rsp_timeout: got none want rsp_valid");
    end
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_count !== 4'd2 || rsp_match !== 1'b0 ||
          busy !== 1'b1 || req_ready !== 2'b00) errs++;
    end
    total++;
    if (errs !== 0) begin
      bad++; $display("FAIL bp_hold: got %0d bad cycles want 0", errs);
    end
    rsp_ready = 1'b1;
    wait_grant(ta, g, ok);
    total++;
    if (!ok || g !== 2'b10) begin
      bad++; $display("FAIL bp_grant1: got %b want 10", g);
    end
    @(posedge clk); #1 req_valid = 2'b00;
    wait_rsp(tr, ok);
    total++;
    if (!ok || (tr - ta) !== 5 || rsp_id !== 1'b1 || rsp_count !== 4'd2) begin
      bad++; $display("FAIL bp_second: got lat=%0d id=%0d cnt=%0d want 5/1/2", tr - ta, rsp_id, rsp_count);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_job();
    int ta, tr;
    logic [1:0] g;
    bit ok;
    int errs;
    do_reset();
    rsp_ready = 1'b1;
    req_data = 16'h000F;
    req_valid = 2'b01;
    wait_grant(ta, g, ok);
    @(posedge clk); #1 req_valid = 2'b00;
    wait_rsp(tr, ok);
    @(negedge clk);
    req_data = 16'hF000;
    req_valid = 2'b10;
    wait_grant(ta, g, ok);
    total++;
    if (!ok || g !== 2'b10 || led !== 1'b1) begin
      bad++; $display("FAIL mid_setup: got grant=%b led=%b want 10/1", g, led);
    end
    @(posedge clk); #1 req_valid = 2'b00;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if ({rsp_valid, busy, led, req_ready, rsp_id, rsp_count, rsp_match} !== '0) begin
      bad++;
      $display("FAIL mid_reset_vals: got valid=%b busy=%b led=%b ready=%b id=%0d cnt=%0d want all 0",
               rsp_valid, busy, led, req_ready, rsp_id, rsp_count);
    end
    errs = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || busy !== 1'b0) errs++;
    end
    total++;
    if (errs !== 0) begin
      bad++; $display("FAIL mid_no_rsp: got %0d bad cycles want 0", errs);
    end
    req_data = 16'h0F81;
    req_valid = 2'b11;
    wait_grant(ta, g, ok);
    total++;
    if (!ok || g !== 2'b01) begin
      bad++; $display("FAIL mid_ptr_zero: got %b want 01", g);
    end
    @(posedge clk); #1 req_valid = 2'b00;
    wait_rsp(tr, ok);
    total++;
    if (!ok || (tr - ta) !== 10 || rsp_id !== 1'b0 || rsp_count !== 4'd2 || rsp_match !== 1'b0) begin
      bad++; $display("FAIL mid_after: got lat=%0d id=%0d cnt=%0d match=%b want 10/0/2/0", tr - ta, rsp_id, rsp_count, rsp_match);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_job();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
